// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS generator/checker: checker states,
// the Fibonacci LFSR step function and common polynomial taps.
package prbs_pkg;

   typedef enum logic [1:0] {
      SEARCH,
      VERIFY,
      LOCKED
   } chk_state_e;

   // Second tap for x^ORDER + x^TAP + 1 primitive polynomials
   localparam int POLY7_TAP  = 6;
   localparam int POLY9_TAP  = 5;
   localparam int POLY15_TAP = 14;
   localparam int POLY23_TAP = 18;
   localparam int POLY31_TAP = 28;

   function automatic logic [31:0] prbs_next(input logic [31:0] state,
                                             input int order,
                                             input int tap);
      logic [31:0] hi;
      logic [31:0] lo;
      logic [31:0] mask;
      hi   = state >> (order - 1);
      lo   = state >> (tap - 1);
      mask = (32'h1 << order) - 32'h1;
      return ((state << 1) & mask) | {31'b0, hi[0] ^ lo[0]};
   endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// ORDER-bit shift register that either steps its own Fibonacci feedback
// or shifts in an external bit; used for both the generator and checker.
module prbs_lfsr
   import prbs_pkg::*;
#(
   parameter int               ORDER   = 7,
   parameter int               TAP     = 6,
   parameter logic [ORDER-1:0] RST_VAL = '1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [ORDER-1:0] load_val,
   input  logic             shift,
   input  logic             use_fb,
   input  logic             shift_in,
   output logic [ORDER-1:0] q
);

   logic [ORDER-1:0] fb_next;

   assign fb_next = ORDER'(prbs_next(32'(q), ORDER, TAP));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= RST_VAL;
      end else if (load) begin
         q <= load_val;
      end else if (shift) begin
         q <= use_fb ? fb_next : {q[ORDER-2:0], shift_in};
      end
   end

endmodule

// File: rtl/prbs_ber_tester.sv
// PRBS BER harness: transmit-side generator plus a self-synchronising
// receive-side checker with lock acquisition, bit/error counting and unlock.
module prbs_ber_tester
   import prbs_pkg::*;
#(
   parameter int               ORDER      = 7,
   parameter int               TAP        = 6,
   parameter logic [ORDER-1:0] SEED       = '1,
   parameter int               LOCK_CNT   = 16,
   parameter int               UNLOCK_WIN = 64,
   parameter int               UNLOCK_ERR = 8,
   parameter int               CNT_W      = 32
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             tx_en,
   input  logic             inject_err,
   output logic             tx_bit,
   output logic [ORDER-1:0] tx_state,
   input  logic             rx_valid,
   input  logic             rx_bit,
   input  logic             clear,
   output logic             locked,
   output logic [CNT_W-1:0] bit_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic             cnt_sat
);

   localparam int FILL_W  = $clog2(ORDER + 1);
   localparam int MATCH_W = $clog2(LOCK_CNT + 1);
   localparam int WIN_W   = $clog2(UNLOCK_WIN + 1);
   localparam int WERR_W  = $clog2(UNLOCK_ERR + 1);

   localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(ORDER - 1);
   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
   localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(UNLOCK_WIN - 1);
   localparam logic [WERR_W-1:0]  WERR_LIMIT = WERR_W'(UNLOCK_ERR);
   localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

   chk_state_e         state, state_nxt;
   logic [ORDER-1:0]   gen_q, chk_q, chk_shifted;
   logic [FILL_W-1:0]  fill_cnt;
   logic [MATCH_W-1:0] match_cnt;
   logic [WIN_W-1:0]   win_cnt;
   logic [WERR_W-1:0]  win_err, win_err_inc;
   logic [CNT_W-1:0]   bit_nxt, err_nxt;
   logic               pred, mismatch, chk_load, chk_use_fb, count_en;

   prbs_lfsr #(.ORDER(ORDER), .TAP(TAP), .RST_VAL(SEED)) u_gen (
      .clk(sys_clk), .rst_n(sys_rst_n), .load(1'b0), .load_val(SEED),
      .shift(tx_en), .use_fb(1'b1), .shift_in(1'b0), .q(gen_q)
   );

   prbs_lfsr #(.ORDER(ORDER), .TAP(TAP), .RST_VAL('0)) u_chk (
      .clk(sys_clk), .rst_n(sys_rst_n), .load(chk_load), .load_val('0),
      .shift(rx_valid), .use_fb(chk_use_fb), .shift_in(rx_bit), .q(chk_q)
   );

   assign tx_state    = gen_q;
   assign pred        = chk_q[ORDER-1] ^ chk_q[TAP-1];
   assign mismatch    = rx_bit ^ pred;
   assign chk_shifted = {chk_q[ORDER-2:0], rx_bit};
   assign win_err_inc = win_err + WERR_W'(mismatch);

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         tx_bit <= 1'b0;
      end else if (tx_en) begin
         tx_bit <= gen_q[ORDER-1] ^ inject_err;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state <= SEARCH;
      end else begin
         state <= state_nxt;
      end
   end

   // An all-zero fill would predict zeros forever, so it is refused
   always_comb begin
      state_nxt = state;
      if (rx_valid) begin
         unique case (state)
            SEARCH:  if (fill_cnt == FILL_LAST && chk_shifted != '0) state_nxt = VERIFY;
            VERIFY:  if (mismatch) state_nxt = SEARCH;
                     else if (match_cnt == MATCH_LAST) state_nxt = LOCKED;
            LOCKED:  if (win_err_inc >= WERR_LIMIT) state_nxt = SEARCH;
            default: state_nxt = SEARCH;
         endcase
      end
   end

   always_comb begin
      chk_load   = rx_valid && (state == VERIFY) && mismatch;
      chk_use_fb = (state != SEARCH);
      count_en   = rx_valid && (state == LOCKED);
      locked     = (state == LOCKED);
   end

   // The error on a window's last bit is judged before the window resets
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         fill_cnt  <= '0;
         match_cnt <= '0;
         win_cnt   <= '0;
         win_err   <= '0;
      end else if (rx_valid) begin
         unique case (state)
            SEARCH: begin
               fill_cnt  <= (fill_cnt == FILL_LAST) ? '0 : fill_cnt + FILL_W'(1);
               match_cnt <= '0;
            end
            VERIFY: begin
               fill_cnt  <= '0;
               match_cnt <= mismatch ? '0 : match_cnt + MATCH_W'(1);
               win_cnt   <= '0;
               win_err   <= '0;
            end
            LOCKED: begin
               match_cnt <= '0;
               if (win_err_inc >= WERR_LIMIT || win_cnt == WIN_LAST) begin
                  win_cnt <= (win_err_inc >= WERR_LIMIT) ? '0 :
                             ((win_cnt == WIN_LAST) ? '0 : win_cnt + WIN_W'(1));
                  win_err <= '0;
               end else begin
                  win_cnt <= win_cnt + WIN_W'(1);
                  win_err <= win_err_inc;
               end
            end
            default: begin
               fill_cnt  <= '0;
               match_cnt <= '0;
            end
         endcase
      end
   end

   always_comb begin
      bit_nxt = bit_cnt;
      err_nxt = err_cnt;
      if (count_en) begin
         if (bit_cnt != CNT_MAX) bit_nxt = bit_cnt + CNT_W'(1);
         if (mismatch && err_cnt != CNT_MAX) err_nxt = err_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n || clear) begin
         bit_cnt <= '0;
         err_cnt <= '0;
         cnt_sat <= 1'b0;
      end else begin
         bit_cnt <= bit_nxt;
         err_cnt <= err_nxt;
         cnt_sat <= cnt_sat | (bit_nxt == CNT_MAX) | (err_nxt == CNT_MAX);
      end
   end

endmodule

// File: tb/tb_prbs_ber_tester.sv
// Directed bench for prbs_ber_tester: generator sequence via a scoreboard,
// loopback lock/unlock timing, lockup guard, saturation/clear and reset.
module tb_prbs_ber_tester;

   logic        sys_clk;
   logic        sys_rst_n, tx_en, inject_err, inject_err2, clear, clear2, rx_force0;
   logic        rx_valid_d, rx_bit1;
   logic        tx_bit, tx_bit2, locked, locked2, cnt_sat, cnt_sat2;
   logic [6:0]  tx_state, tx_state2;
   logic [31:0] bit_cnt, err_cnt;
   logic [3:0]  bit_cnt2, err_cnt2;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   ones = 0;
   logic [6:0] model;
   logic exp_q[$];

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) rx_valid_d <= tx_en;
   assign rx_bit1 = rx_force0 ? 1'b0 : tx_bit;

   prbs_ber_tester dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_en(tx_en), .inject_err(inject_err),
      .tx_bit(tx_bit), .tx_state(tx_state), .rx_valid(rx_valid_d), .rx_bit(rx_bit1),
      .clear(clear), .locked(locked), .bit_cnt(bit_cnt), .err_cnt(err_cnt), .cnt_sat(cnt_sat)
   );

   prbs_ber_tester #(.CNT_W(4), .UNLOCK_ERR(20)) dut2 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_en(tx_en), .inject_err(inject_err2),
      .tx_bit(tx_bit2), .tx_state(tx_state2), .rx_valid(rx_valid_d), .rx_bit(tx_bit2),
      .clear(clear2), .locked(locked2), .bit_cnt(bit_cnt2), .err_cnt(err_cnt2), .cnt_sat(cnt_sat2)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock edge; expected tx_bit is queued at the strobe and retired after it
   task automatic applyStimulus(input logic en, input logic inj);
      logic e;
      tx_en      = en;
      inject_err = inj;
      if (en) begin
         exp_q.push_back(model[6] ^ inj);
         model = {model[5:0], model[6] ^ model[5]};
      end
      @(posedge sys_clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checkOutput("tx_bit", 32'(tx_bit), 32'(e));
         if (tx_bit) ones++;
      end
   endtask

   task automatic doReset();
      sys_rst_n   = 1'b0;
      tx_en       = 1'b0;
      inject_err  = 1'b0;
      inject_err2 = 1'b0;
      clear       = 1'b0;
      clear2      = 1'b0;
      @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      model     = 7'h7F;
      exp_q.delete();
      ones      = 0;
      cyc       = 0;
   endtask

   initial begin
      logic lock_seen;
      rx_force0 = 1'b0;
      doReset();
      checkOutput("rst_tx_bit", 32'(tx_bit), 32'd0);
      checkOutput("rst_tx_state", 32'(tx_state), 32'h7F);
      checkOutput("rst_locked", 32'(locked), 32'd0);
      checkOutput("rst_bit_cnt", bit_cnt, 32'd0);
      checkOutput("rst_err_cnt", err_cnt, 32'd0);
      checkOutput("rst_cnt_sat", 32'(cnt_sat), 32'd0);

      while (cyc < 23) applyStimulus(1'b1, 1'b0);
      checkOutput("lock_before_23rd", 32'(locked), 32'd0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("lock_at_23rd", 32'(locked), 32'd1);
      checkOutput("bit_cnt_at_lock", bit_cnt, 32'd0);
      while (cyc < 30) applyStimulus(1'b1, 1'b0);
      checkOutput("bit_cnt_6", bit_cnt, 32'd6);
      while (cyc < 127) applyStimulus(1'b1, 1'b0);
      checkOutput("period_state", 32'(tx_state), 32'h7F);
      checkOutput("period_ones", 32'(ones), 32'd64);
      checkOutput("bit_cnt_103", bit_cnt, 32'd103);
      checkOutput("err_cnt_clean", err_cnt, 32'd0);

      while (cyc < 129) applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0);
      checkOutput("single_err_cnt", err_cnt, 32'd1);
      checkOutput("single_err_locked", 32'(locked), 32'd1);

      while (cyc < 152) applyStimulus(1'b1, 1'b0);
      for (int k = 0; k < 7; k++) begin
         applyStimulus(1'b1, 1'b1);
         repeat (3) applyStimulus(1'b1, 1'b0);
      end
      checkOutput("seven_err_cnt", err_cnt, 32'd8);
      checkOutput("seven_err_locked", 32'(locked), 32'd1);

      while (cyc < 219) applyStimulus(1'b1, 1'b0);
      for (int k = 0; k < 8; k++) applyStimulus(1'b1, 1'b1);
      checkOutput("seventh_burst_locked", 32'(locked), 32'd1);
      checkOutput("seventh_burst_err", err_cnt, 32'd15);
      applyStimulus(1'b1, 1'b0);
      checkOutput("eighth_err_unlock", 32'(locked), 32'd0);
      checkOutput("eighth_err_cnt", err_cnt, 32'd16);
      while (cyc < 250) applyStimulus(1'b1, 1'b0);
      checkOutput("relock_early", 32'(locked), 32'd0);
      checkOutput("bit_cnt_held", bit_cnt, 32'd204);
      applyStimulus(1'b1, 1'b0);
      checkOutput("relock_23rd", 32'(locked), 32'd1);

      // Reset while locked, with every other input active
      applyStimulus(1'b1, 1'b0);
      sys_rst_n  = 1'b0;
      tx_en      = 1'b1;
      inject_err = 1'b1;
      clear      = 1'b0;
      @(posedge sys_clk);
      #1;
      sys_rst_n  = 1'b1;
      tx_en      = 1'b0;
      inject_err = 1'b0;
      model      = 7'h7F;
      exp_q.delete();
      cyc        = 0;
      checkOutput("mid_rst_tx_bit", 32'(tx_bit), 32'd0);
      checkOutput("mid_rst_tx_state", 32'(tx_state), 32'h7F);
      checkOutput("mid_rst_locked", 32'(locked), 32'd0);
      checkOutput("mid_rst_bit_cnt", bit_cnt, 32'd0);
      checkOutput("mid_rst_err_cnt", err_cnt, 32'd0);
      checkOutput("mid_rst_cnt_sat", 32'(cnt_sat), 32'd0);

      rx_force0 = 1'b1;
      lock_seen = 1'b0;
      repeat (200) begin
         applyStimulus(1'b1, 1'b0);
         lock_seen = lock_seen | locked;
      end
      checkOutput("zeros_never_lock", 32'(lock_seen), 32'd0);
      rx_force0 = 1'b0;

      doReset();
      while (cyc < 23) applyStimulus(1'b1, 1'b0);
      checkOutput("d2_lock_early", 32'(locked2), 32'd0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("d2_lock", 32'(locked2), 32'd1);
      while (cyc < 29) applyStimulus(1'b1, 1'b0);
      inject_err2 = 1'b1;
      while (cyc < 45) applyStimulus(1'b1, 1'b0);
      checkOutput("d2_err_15", 32'(err_cnt2), 32'd15);
      checkOutput("d2_sat", 32'(cnt_sat2), 32'd1);
      applyStimulus(1'b1, 1'b0);
      checkOutput("d2_err_stuck", 32'(err_cnt2), 32'd15);
      checkOutput("d2_bit_stuck", 32'(bit_cnt2), 32'd15);
      clear2      = 1'b1;
      inject_err2 = 1'b0;
      applyStimulus(1'b1, 1'b0);
      checkOutput("d2_clear_err", 32'(err_cnt2), 32'd0);
      checkOutput("d2_clear_bit", 32'(bit_cnt2), 32'd0);
      checkOutput("d2_clear_sat", 32'(cnt_sat2), 32'd0);
      clear2 = 1'b0;
      applyStimulus(1'b1, 1'b0);
      checkOutput("d2_after_clear_bit", 32'(bit_cnt2), 32'd1);
      checkOutput("d2_after_clear_err", 32'(err_cnt2), 32'd0);
      checkOutput("d2_still_locked", 32'(locked2), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prbs_ber_tester.md
Name: prbs_ber_tester

Overview:
- Parametrised successor to the single fixed-length M-sequence source in the transmit/receive link.
- One block holds a configurable-order Fibonacci PRBS generator for the transmitter side and a self-synchronising PRBS checker for the receiver side.
- The checker acquires lock, counts bits and bit errors, and drops lock on excessive errors.
- Used as the link's BER test harness around the transmitter/channel/receiver chain.

Parameters:
- ORDER, 7, LFSR length; polynomial is x^ORDER + x^TAP + 1 (legal: 3..31).
- TAP, 6, second feedback tap (1 <= TAP < ORDER).
- SEED, all ones (ORDER bits), generator reset value; must be nonzero.
- LOCK_CNT, 16, consecutive correct predictions needed to declare lock.
- UNLOCK_WIN, 64, error-monitor window length in counted bits.
- UNLOCK_ERR, 8, errors within one window that force loss of lock.
- CNT_W, 32, width of the bit and error counters.

Ports:
- sys_clk, input, 1, single clock for the whole block.
- sys_rst_n, input, 1, synchronous active-low reset.
- tx_en, input, 1, generator bit strobe.
- inject_err, input, 1, sampled with tx_en; inverts the emitted bit.
- tx_bit, output, 1, registered PRBS output bit.
- tx_state, output, ORDER, current generator LFSR contents.
- rx_valid, input, 1, received-bit strobe.
- rx_bit, input, 1, received bit.
- clear, input, 1, zeroes counters and saturation flags.
- locked, output, 1, checker in LOCKED state.
- bit_cnt, output, CNT_W, bits compared while locked.
- err_cnt, output, CNT_W, errors counted while locked.
- cnt_sat, output, 1, sticky flag: either counter saturated.

Behaviour:
- Reset (sys_rst_n=0 at a sys_clk edge) sets:
  - lfsr=SEED, tx_bit=0, tx_state=SEED.
  - Checker state SEARCH, chk register 0, fill/match/window counters 0.
  - locked=0, bit_cnt=0, err_cnt=0, cnt_sat=0.
- Reset takes priority over every other input; reset mid-acquisition or mid-lock returns to SEARCH with no residue.
- Generator, on tx_en=1:
  - tx_bit <= lfsr[ORDER-1] ^ inject_err.
  - lfsr <= {lfsr[ORDER-2:0], lfsr[ORDER-1]^lfsr[TAP-1]}.
- Generator with tx_en=0: all generator state holds.
- Generator latency: 1 cycle from strobe to tx_bit.
- inject_err never alters the lfsr. Sequence period is 2^ORDER-1 strobes for a primitive polynomial.
- Checker predicted bit: p = chk[ORDER-1]^chk[TAP-1]. The checker acts only on rx_valid=1 cycles; otherwise all checker state holds.
- SEARCH:
  - chk <= {chk[ORDER-2:0], rx_bit}; fill counter increments.
  - When ORDER bits have been loaded: if chk is all-zero, stay in SEARCH with fill reset (lockup guard); else go to VERIFY with match=0.
- VERIFY:
  - Compare rx_bit to p; chk shifts in p (free-running).
  - Match: match+1; on reaching LOCK_CNT go to LOCKED with window=0 and window errors=0.
  - Mismatch: go to SEARCH with fill=0 and chk=0.
- LOCKED:
  - chk shifts in p.
  - bit_cnt+1; on mismatch err_cnt+1 and window errors+1.
  - Window counter wraps at UNLOCK_WIN, clearing window errors.
  - If window errors reach UNLOCK_ERR, go to SEARCH on the same edge; counters keep their values.
- locked is registered and equals (state==LOCKED).
- Lock timing with an error-free input: locked rises on the edge of the (ORDER+LOCK_CNT)th rx_valid bit; default is the 23rd.
- Counters saturate at 2^CNT_W-1 and stop; saturation of either sets cnt_sat, which is sticky until clear or reset.
- clear:
  - Zeroes bit_cnt, err_cnt and cnt_sat.
  - Has priority over a same-cycle increment; that bit is not counted.
  - Does not affect checker state or lock.
- Simultaneous window wrap and error: the error belongs to the closing window. Evaluate it against UNLOCK_ERR first, then reset window errors.
- Generator and checker are independent; tx_en and rx_valid may be asserted on the same or different cycles.

Decomposition:
- Shared package prbs_pkg holds:
  - Checker state enum (SEARCH, VERIFY, LOCKED).
  - Function prbs_next(state, order, tap) returning the next LFSR value.
  - Default polynomial constants for orders 7, 9, 15, 23, 31.
- One natural sub-module, prbs_lfsr: an ORDER/TAP-parametrised shift register with load, shift and shift-in-feedback controls. Instantiate it twice, once as the generator and once as the checker chk register.

Test Plan:
- Reset then 127 tx_en strobes with defaults -> tx_state returns to 7'h7F; exactly 64 ones among the 127 tx_bit values.
- Loop tx_bit to rx_bit with rx_valid=tx_en delayed 1 cycle -> locked rises at the 23rd valid bit; bit_cnt increments 1 per bit and err_cnt stays 0.
- After lock, one inject_err pulse -> err_cnt=1, locked stays 1; 7 errors in 64 bits -> still locked; 8 errors in 64 bits -> locked falls on the 8th error, then relocks 23 valid bits later.
- rx_bit held 0 for 200 valid strobes -> locked never asserts; state stays SEARCH.
- CNT_W=4, continuous inject_err after lock -> err_cnt stops at 15, cnt_sat=1; clear with a simultaneous error -> err_cnt=0, cnt_sat=0.
- sys_rst_n low for 1 cycle while LOCKED -> all outputs at reset values the next cycle; tx_state=SEED.
